// File: rtl/seg_page_sched_pkg.sv
// Shared types for the seven-segment page scheduler and display driver:
// BCD page type, commit FSM states and the segment decode table.
package seg_pkg;

  localparam int NREQ_MAX = 8;

  typedef logic [7:0][3:0] bcd8_t;

  typedef enum logic [0:0] {IDLE = 1'b0, PEND = 1'b1} commit_st_t;

  // Active-high segments {g,f,e,d,c,b,a}; non-decimal codes blank the digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_page_sched_key_debounce.sv
// Key conditioner: 2-flop synchronizer, stability counter and a one-cycle
// press pulse on the debounced 0->1 transition.
module key_debounce #(
  parameter int DEB_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic key_press
);

  localparam int CW = $clog2(DEB_CYC + 1);

  logic [1:0]    r_sync;
  logic          r_state;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  // The flip lands one edge after DEB_CYC differing samples have been counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b00;
      r_state <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync  <= {r_sync[0], key_raw};
      r_press <= 1'b0;
      if (r_sync[1] == r_state) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEB_CYC)) begin
        r_state <= ~r_state;
        r_press <= ~r_state;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign key_press = r_press;

endmodule

// File: rtl/seg_page_sched.sv
// Page scheduler: per-producer shadows, key-driven page select/freeze and a
// frame-aligned commit to the shift-out engine. Auto-rotate: SEG_AUTOROT_EN.
module seg_page_sched
  import seg_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DEB_CYC = 16,
  parameter int ROT_CYC = 50_000_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     key0,
  input  logic                     key1,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*32-1:0]       req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     frame_sync,
  output logic [31:0]              dis_data,
  output logic                     dis_upd,
  output logic [$clog2(NREQ)-1:0]  page,
  output logic                     frozen,
  output logic [1:0]               led
);

  localparam int         PW     = $clog2(NREQ);
  localparam logic [0:0] S_IDLE = IDLE;
  localparam logic [0:0] S_PEND = PEND;

  logic            w_key0_press;
  logic            w_key1_press;
  logic            w_advance;
  logic            w_commit;
  logic [NREQ-1:0] w_xfer;

  bcd8_t           r_shadow [NREQ];
  logic            r_fresh  [NREQ];
  logic [PW-1:0]   r_page;
  logic            r_dirty;
  logic            r_frozen;
  logic [0:0]      r_state;
  bcd8_t           r_dis_data;
  logic            r_dis_upd;

  key_debounce #(.DEB_CYC(DEB_CYC)) u_key0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_raw   (key0),
    .key_press (w_key0_press)
  );

  key_debounce #(.DEB_CYC(DEB_CYC)) u_key1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_raw   (key1),
    .key_press (w_key1_press)
  );

  assign req_ready = {NREQ{~r_frozen}};
  assign w_commit  = (r_state == S_PEND) && frame_sync;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign w_xfer[gi] = req_valid[gi] & req_ready[gi];

    // A same-cycle transfer keeps fresh set so the newer value commits next frame.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_shadow[gi] <= '0;
        r_fresh[gi]  <= 1'b0;
      end else begin
        if (w_xfer[gi]) begin
          r_shadow[gi] <= req_data[gi*32 +: 32];
          r_fresh[gi]  <= 1'b1;
        end else if (w_commit && (r_page == PW'(gi))) begin
          r_fresh[gi]  <= 1'b0;
        end
      end
    end
  end

`ifdef SEG_AUTOROT_EN
  localparam int RW = $clog2(ROT_CYC);

  logic [RW-1:0] r_rot_cnt;
  logic          w_rot_tick;

  assign w_rot_tick = !r_frozen && (r_rot_cnt == RW'(ROT_CYC - 1));
  assign w_advance  = w_key0_press | w_rot_tick;

  // Freezing holds the count so rotation resumes where it left off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rot_cnt <= '0;
    end else if (w_key0_press || w_rot_tick) begin
      r_rot_cnt <= '0;
    end else if (!r_frozen) begin
      r_rot_cnt <= r_rot_cnt + 1'b1;
    end
  end
`else
  assign w_advance = w_key0_press;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_page   <= '0;
      r_dirty  <= 1'b0;
      r_frozen <= 1'b0;
    end else begin
      if (w_advance) begin
        r_page  <= r_page + 1'b1;
        r_dirty <= 1'b1;
      end else if (w_commit) begin
        r_dirty <= 1'b0;
      end
      if (w_key1_press) begin
        r_frozen <= ~r_frozen;
      end
    end
  end

  // Commit samples the page current at frame_sync, so late page changes win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_dis_data <= '0;
      r_dis_upd  <= 1'b0;
    end else begin
      r_dis_upd <= w_commit;
      case (r_state)
        S_IDLE: begin
          if (r_fresh[r_page] || r_dirty) begin
            r_state <= S_PEND;
          end
        end
        default: begin
          if (frame_sync) begin
            r_dis_data <= r_shadow[r_page];
            r_state    <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign dis_data = r_dis_data;
  assign dis_upd  = r_dis_upd;
  assign page     = r_page;
  assign frozen   = r_frozen;

  if (PW == 1) begin : g_led_narrow
    assign led = {1'b0, r_page};
  end else begin : g_led_wide
    assign led = r_page[1:0];
  end

endmodule

// File: tb/tb_seg_page_sched.sv
// Scoreboard bench for seg_page_sched: expected pages queued when a commit is
// provoked, popped by a monitor on each dis_upd pulse.
module tb_seg_page_sched;

  localparam int NREQ    = 4;
  localparam int DEB_CYC = 4;
  localparam int ROT_CYC = 20;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 key0 = 1'b0;
  logic                 key1 = 1'b0;
  logic                 frame_sync = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*32-1:0]   req_data = '0;
  logic [NREQ-1:0]      req_ready;
  logic [31:0]          dis_data;
  logic                 dis_upd;
  logic [1:0]           page;
  logic                 frozen;
  logic [1:0]           led;

  int          checks = 0;
  int          failures = 0;
  int          n_upd = 0;
  int          exp_upd = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  seg_page_sched #(
    .NREQ    (NREQ),
    .DEB_CYC (DEB_CYC),
    .ROT_CYC (ROT_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key0       (key0),
    .key1       (key1),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .frame_sync (frame_sync),
    .dis_data   (dis_data),
    .dis_upd    (dis_upd),
    .page       (page),
    .frozen     (frozen),
    .led        (led)
  );

  // Scoreboard monitor: every dis_upd pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && dis_upd === 1'b1) begin
      logic [31:0] exp_val;
      n_upd++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL upd_unexpected: dis_data=%h with no commit expected", dis_data);
      end else begin
        exp_val = exp_q.pop_front();
        if (dis_data !== exp_val) begin
          failures++;
          $display("FAIL upd_data: dis_data=%h expected %h", dis_data, exp_val);
        end else begin
          $display("upd #%0d dis_data=%h ok", n_upd, dis_data);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_req(input int idx, input logic v, input logic [31:0] d);
    req_data[idx*32 +: 32] = d;
    req_valid[idx] = v;
  endtask

  task automatic press_key(input int which, input int hi, input int lo);
    if (which == 0) key0 = 1'b1; else key1 = 1'b1;
    tick(hi);
    if (which == 0) key0 = 1'b0; else key1 = 1'b0;
    tick(lo);
  endtask

  task automatic test_reset();
    tick(1);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (dis_data !== 32'h0) begin failures++; $display("FAIL rst_dis_data: got %h expected 0", dis_data); end
    checks++; if (dis_upd !== 1'b0) begin failures++; $display("FAIL rst_dis_upd: got %b expected 0", dis_upd); end
    checks++; if (page !== 2'd0) begin failures++; $display("FAIL rst_page: got %0d expected 0", page); end
    checks++; if (led !== 2'd0) begin failures++; $display("FAIL rst_led: got %0d expected 0", led); end
    checks++; if (frozen !== 1'b0) begin failures++; $display("FAIL rst_frozen: got %b expected 0", frozen); end
    checks++; if (req_ready !== 4'b1111) begin failures++; $display("FAIL rst_req_ready: got %b expected 1111", req_ready); end
    tick(2);
    rst_n = 1'b1;
    $display("reset released, outputs at reset values");
  endtask

  task automatic test_single_commit();
    checks++; if (req_ready !== 4'b1111) begin failures++; $display("FAIL ready_after_reset: got %b expected 1111", req_ready); end
    drive_req(0, 1'b1, 32'h0000_1234);
    tick(1);
    drive_req(0, 1'b0, 32'h0);
    tick(2);
    frame_sync = 1'b1;
    exp_q.push_back(32'h0000_1234); exp_upd++;
    tick(1);
    frame_sync = 1'b0;
    checks++; if (dis_upd !== 1'b1) begin failures++; $display("FAIL commit_upd: got %b expected 1", dis_upd); end
    checks++; if (dis_data !== 32'h0000_1234) begin failures++; $display("FAIL commit_data: got %h expected 00001234", dis_data); end
    tick(1);
    checks++; if (dis_upd !== 1'b0) begin failures++; $display("FAIL commit_pulse_width: got %b expected 0", dis_upd); end
    frame_sync = 1'b1;
    tick(1);
    frame_sync = 1'b0;
    checks++; if (dis_upd !== 1'b0) begin failures++; $display("FAIL fresh_cleared: got dis_upd=%b expected 0", dis_upd); end
    tick(2);
    $display("single commit of producer 0 done");
  endtask

  task automatic test_key0_wrap();
    for (int p = 1; p <= 3; p++) begin
      press_key(0, 8, 8);
      checks++; if (page !== 2'(p)) begin failures++; $display("FAIL key0_step: got page %0d expected %0d", page, p); end
    end
    checks++; if (led !== 2'd3) begin failures++; $display("FAIL led_page3: got %0d expected 3", led); end
    key0 = 1'b1;
    tick(7);
    checks++; if (page !== 2'd3) begin failures++; $display("FAIL key0_early: got page %0d expected 3 before edge 7", page); end
    tick(1);
    checks++; if (page !== 2'd0) begin failures++; $display("FAIL key0_wrap: got page %0d expected 0 at edge 7", page); end
    checks++; if (led !== 2'd0) begin failures++; $display("FAIL led_wrap: got %0d expected 0", led); end
    tick(2);
    key0 = 1'b0;
    tick(8);
    frame_sync = 1'b1;
    exp_q.push_back(32'h0000_1234); exp_upd++;
    tick(1);
    frame_sync = 1'b0;
    checks++; if (dis_upd !== 1'b1 || dis_data !== 32'h0000_1234) begin
      failures++; $display("FAIL wrap_commit: got upd=%b data=%h expected 1/00001234", dis_upd, dis_data);
    end
    tick(2);
    $display("key0 wrap 3->0 and page commit done");
  endtask

  task automatic test_bounce();
    key0 = 1'b1; tick(1);
    key0 = 1'b0; tick(1);
    key0 = 1'b1; tick(1);
    key0 = 1'b0; tick(12);
    checks++; if (page !== 2'd0) begin failures++; $display("FAIL bounce_page: got %0d expected 0", page); end
    frame_sync = 1'b1; tick(1); frame_sync = 1'b0;
    checks++; if (dis_upd !== 1'b0) begin failures++; $display("FAIL bounce_no_commit: got dis_upd=%b expected 0", dis_upd); end
    tick(2);
    $display("key0 bounce rejected");
  endtask

  task automatic test_freeze();
    press_key(1, 8, 8);
    checks++; if (frozen !== 1'b1) begin failures++; $display("FAIL freeze_on: got %b expected 1", frozen); end
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL freeze_ready: got %b expected 0000", req_ready); end
    drive_req(0, 1'b1, 32'h0000_5678);
    tick(1);
    frame_sync = 1'b1; tick(1); frame_sync = 1'b0;
    tick(2);
    checks++; if (dis_upd !== 1'b0) begin failures++; $display("FAIL freeze_no_xfer: got dis_upd=%b expected 0", dis_upd); end
    key1 = 1'b1;
    tick(7);
    checks++; if (frozen !== 1'b1) begin failures++; $display("FAIL unfreeze_early: got %b expected 1", frozen); end
    tick(1);
    checks++; if (frozen !== 1'b0) begin failures++; $display("FAIL unfreeze: got %b expected 0", frozen); end
    checks++; if (req_ready !== 4'b1111) begin failures++; $display("FAIL unfreeze_ready: got %b expected 1111", req_ready); end
    tick(1);
    drive_req(0, 1'b0, 32'h0);
    key1 = 1'b0;
    tick(8);
    frame_sync = 1'b1;
    exp_q.push_back(32'h0000_5678); exp_upd++;
    tick(1);
    frame_sync = 1'b0;
    checks++; if (dis_data !== 32'h0000_5678) begin failures++; $display("FAIL unfreeze_commit: got %h expected 00005678", dis_data); end
    tick(2);
    $display("freeze back-pressure and release done");
  endtask

  task automatic test_coincident();
    drive_req(0, 1'b1, 32'h0000_9999);
    tick(1);
    drive_req(0, 1'b0, 32'h0);
    tick(1);
    frame_sync = 1'b1;
    drive_req(0, 1'b1, 32'h0000_4321);
    exp_q.push_back(32'h0000_9999); exp_upd++;
    tick(1);
    frame_sync = 1'b0;
    drive_req(0, 1'b0, 32'h0);
    checks++; if (dis_data !== 32'h0000_9999) begin failures++; $display("FAIL coincide_old: got %h expected 00009999", dis_data); end
    tick(2);
    frame_sync = 1'b1;
    exp_q.push_back(32'h0000_4321); exp_upd++;
    tick(1);
    frame_sync = 1'b0;
    checks++; if (dis_data !== 32'h0000_4321) begin failures++; $display("FAIL coincide_new: got %h expected 00004321", dis_data); end
    tick(2);
    $display("coincident write/frame_sync done");
  endtask

  task automatic test_reset_mid_pend();
    drive_req(0, 1'b1, 32'h0000_7777);
    tick(1);
    drive_req(0, 1'b0, 32'h0);
    tick(2);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (dis_data !== 32'h0 || dis_upd !== 1'b0) begin
      failures++; $display("FAIL pend_reset: got data=%h upd=%b expected 0/0", dis_data, dis_upd);
    end
    tick(1);
    rst_n = 1'b1;
    tick(3);
    frame_sync = 1'b1; tick(1); frame_sync = 1'b0;
    checks++; if (dis_upd !== 1'b0) begin failures++; $display("FAIL pend_aborted: got dis_upd=%b expected 0", dis_upd); end
    tick(2);
    $display("reset mid-PEND aborted the commit");
  endtask

`ifdef SEG_AUTOROT_EN
  task automatic test_rotate();
    tick(19);
    checks++; if (page !== 2'd0) begin failures++; $display("FAIL rot_early: got page %0d expected 0", page); end
    tick(1);
    checks++; if (page !== 2'd1) begin failures++; $display("FAIL rot_step: got page %0d expected 1", page); end
    key1 = 1'b1;
    tick(8);
    key1 = 1'b0;
    checks++; if (frozen !== 1'b1) begin failures++; $display("FAIL rot_freeze: got %b expected 1", frozen); end
    tick(40);
    checks++; if (page !== 2'd1) begin failures++; $display("FAIL rot_frozen_hold: got page %0d expected 1", page); end
    key1 = 1'b1;
    tick(8);
    checks++; if (frozen !== 1'b0) begin failures++; $display("FAIL rot_unfreeze: got %b expected 0", frozen); end
    tick(11);
    checks++; if (page !== 2'd1) begin failures++; $display("FAIL rot_resume_early: got page %0d expected 1", page); end
    tick(1);
    checks++; if (page !== 2'd2) begin failures++; $display("FAIL rot_resume: got page %0d expected 2", page); end
    key1 = 1'b0;
    tick(8);
    $display("auto-rotate with freeze hold done");
  endtask
`endif

  initial begin
    test_reset();
`ifdef SEG_AUTOROT_EN
    test_rotate();
`else
    test_single_commit();
    test_key0_wrap();
    test_bounce();
    test_freeze();
    test_coincident();
    test_reset_mid_pend();
`endif
    tick(2);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL sb_leftover: %0d commits outstanding, expected 0", exp_q.size()); end
    checks++; if (n_upd != exp_upd) begin failures++; $display("FAIL upd_count: got %0d expected %0d", n_upd, exp_upd); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
